led_chain_driver: RTL and testbench
===================================

Name: led_chain_driver

Overview:
- Parametrised successor to the team's single-chain 16-bit serial LED driver.
- Accepts a frame of one WIDTH-bit word per chain through a valid/ready handshake.
- Shifts all CHANNELS words out in parallel on a divided shift clock, then pulses an active-low latch.
- Optionally refreshes the held frame continuously.
- Sits between the display/control logic and the external shift-register LED chains.

Parameters:
- CHANNELS, 1, number of parallel serial data outputs sharing sclk/latch.
- WIDTH, 16, bits per chain per frame; must be a multiple of 8 when BYTE_SWAP=1.
- DIV, 1, system clocks per sclk half-period (>=1).
- LATCH_CYCLES, 1, system clocks latch is held low (>=1).
- GAP_CYCLES, 0, idle system clocks after latch before next frame (>=0).
- MSB_FIRST, 1, 1 = shift MSB of the (swapped) word first; 0 = LSB first.
- BYTE_SWAP, 1, 1 = reverse byte order within each channel word before shifting.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- frame_data  in  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- frame_valid  in  1  frame_data valid.
- frame_ready  out  1  block can accept a frame.
- repeat_en  in  1  re-send the held frame when no new frame is offered.
- sclk  out  1  shift clock to chains; data is stable on its rising edge.
- sdata  out  CHANNELS  serial data, one bit per chain.
- latch  out  1  active-low storage latch strobe; idle high.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse when latch returns high.

Behaviour:
- Clock and reset:
  - One clock. Reset is synchronous and active-high.
  - Reset is sampled on the clk edge and overrides everything, including a frame mid-shift.
  - Reset values: state=IDLE, sclk=0, sdata=0, latch=1, busy=0, frame_done=0, counters=0, held frame=0.
- frame_ready = (state==IDLE) && !rst; combinational.
- States and transitions:
  - IDLE: sclk=0, latch=1.
    - On frame_valid&&frame_ready: capture frame_data (after BYTE_SWAP) into per-channel shift registers and into a hold copy; go to SHIFT.
  - SHIFT: bit counter 0..WIDTH-1; half-period counter 0..DIV-1.
    - Each bit: sclk low for DIV cycles with sdata driven, then sclk high for DIV cycles.
    - sdata changes only on the cycle sclk goes low, never while sclk is high.
    - After the high half of bit WIDTH-1: sclk=0, go to LATCH.
  - LATCH: latch=0 for LATCH_CYCLES cycles; sdata holds its last bit.
    - On exit, latch=1 and frame_done=1 for that one cycle.
    - Go to GAP if GAP_CYCLES>0, else apply the GAP exit rule immediately.
  - GAP: wait GAP_CYCLES cycles, then apply the exit rule:
    - frame_valid high: accept the new frame; frame_ready is asserted combinationally in that cycle via a transient IDLE.
    - else repeat_en high: reload the shift registers from the hold copy and go to SHIFT.
    - else go to IDLE.
- Latency:
  - First bit appears on sdata in the cycle after acceptance, with sclk=0.
  - First sclk rise occurs DIV cycles after that.
  - Frame period = 2*DIV*WIDTH + LATCH_CYCLES + GAP_CYCLES (+1 if a return to IDLE is required).
- Bit order:
  - BYTE_SWAP reverses byte k to byte WIDTH/8-1-k per channel.
  - MSB_FIRST selects shifting the swapped word from bit WIDTH-1 down or from bit 0 up.
  - With defaults, word 0xABCD shifts out as 0xCD bits MSB-first, then 0xAB bits MSB-first.
- Boundary conditions:
  - frame_valid while busy is ignored; frame_data changes during SHIFT do not affect output.
  - The hold copy updates only on acceptance.
  - repeat_en changes take effect only at the GAP exit decision.
  - frame_valid and repeat_en both high at the exit decision: the new frame wins.
  - Channels are always bit-synchronous.

Test Plan:
- Defaults (CHANNELS=1, WIDTH=16, DIV=1): reset, then offer 0xABCD for one cycle.
  - Sampled sdata on sclk rises = 1100_1101_1010_1011.
  - latch low exactly 1 cycle, 33 cycles after acceptance; frame_done pulses with latch rising; busy low afterwards.
- CHANNELS=2, DIV=2, BYTE_SWAP=0, MSB_FIRST=0; frame {0x8001, 0x00FF}.
  - ch0 bits 1×8 then 0×8; ch1 bits 1,0×14,1.
  - Each sclk level lasts 2 cycles; total 64 cycles to latch.
- repeat_en=1, GAP_CYCLES=3, no further frame_valid.
  - Identical frames repeat every 2*DIV*WIDTH+LATCH_CYCLES+3 cycles, with frame_done each time.
- repeat_en=1 and a new frame 0x1234 offered during SHIFT.
  - Ignored until the GAP exit; the next frame is 0x1234 and not the repeat.
- Assert rst for 1 cycle mid-SHIFT at bit 7.
  - Next cycle: sclk=0, latch=1, sdata=0, busy=0, frame_ready=1 after rst drops, no latch pulse.
  - A subsequent frame shifts normally.
- LATCH_CYCLES=4: latch low exactly 4 consecutive cycles, sclk stays 0 and sdata stable throughout.

Source files
------------

// File: rtl/led_chain_driver.sv
// Serial LED chain driver: takes one WIDTH-bit word per chain, shifts all
// chains out in parallel on a divided sclk, then strobes an active-low latch.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   frame_data    channel c in bits [c*WIDTH +: WIDTH]
//   frame_valid   frame offer; frame_ready high only in IDLE
//   repeat_en     resend the held frame when nothing new is offered
//   sclk, sdata   shift clock and one data bit per chain
//   latch         active-low storage strobe, idle high
//   busy          not in IDLE
//   frame_done    one-cycle pulse as latch returns high
module led_chain_driver #(
    parameter int CHANNELS     = 1,
    parameter int WIDTH        = 16,
    parameter int DIV          = 1,
    parameter int LATCH_CYCLES = 1,
    parameter int GAP_CYCLES   = 0,
    parameter int MSB_FIRST    = 1,
    parameter int BYTE_SWAP    = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] frame_data,
    input  logic                      frame_valid,
    output logic                      frame_ready,
    input  logic                      repeat_en,
    output logic                      sclk,
    output logic [CHANNELS-1:0]       sdata,
    output logic                      latch,
    output logic                      busy,
    output logic                      frame_done
);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH, GAP} state_t;

    localparam int NB = WIDTH / 8;

    state_t state, state_d;
    logic   load_new, load_hold, exit_now;
    logic [31:0] hcnt, bcnt, cnt;
    logic [CHANNELS-1:0][WIDTH-1:0] sr, hold, new_w, src_w;

    // Words are stored pre-ordered so the shifter always emits bit WIDTH-1.
    function automatic logic [WIDTH-1:0] prep(input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] r;
        s = d;
        if (BYTE_SWAP != 0) begin
            for (int k = 0; k < NB; k++) begin
                s[k*8 +: 8] = d[(NB-1-k)*8 +: 8];
            end
        end
        r = s;
        if (MSB_FIRST == 0) begin
            for (int i = 0; i < WIDTH; i++) begin
                r[i] = s[WIDTH-1-i];
            end
        end
        return r;
    endfunction

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            new_w[c] = prep(frame_data[c*WIDTH +: WIDTH]);
        end
        src_w = load_new ? new_w : hold;
    end

    assign frame_ready = (state == IDLE) && !rst;
    assign busy        = (state != IDLE);

    always_comb begin
        state_d   = state;
        load_new  = 1'b0;
        load_hold = 1'b0;
        exit_now  = 1'b0;
        unique case (state)
            IDLE: begin
                if (frame_valid) begin
                    state_d  = SHIFT;
                    load_new = 1'b1;
                end
            end
            SHIFT: begin
                if (hcnt == 32'(DIV-1) && sclk && bcnt == 32'(WIDTH-1)) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                if (cnt == 32'(LATCH_CYCLES-1)) begin
                    if (GAP_CYCLES > 0) state_d = GAP;
                    else                exit_now = 1'b1;
                end
            end
            GAP: begin
                if (cnt == 32'(GAP_CYCLES-1)) exit_now = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // A pending frame goes through IDLE so it is taken by the handshake.
        if (exit_now) begin
            if (!frame_valid && repeat_en) begin
                state_d   = SHIFT;
                load_hold = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sclk       <= 1'b0;
            sdata      <= '0;
            latch      <= 1'b1;
            frame_done <= 1'b0;
            hcnt       <= '0;
            bcnt       <= '0;
            cnt        <= '0;
            sr         <= '0;
            hold       <= '0;
        end else begin
            state      <= state_d;
            frame_done <= 1'b0;
            unique case (state)
                SHIFT: begin
                    if (hcnt == 32'(DIV-1)) begin
                        hcnt <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else begin
                            sclk <= 1'b0;
                            if (bcnt == 32'(WIDTH-1)) begin
                                latch <= 1'b0;
                                cnt   <= '0;
                            end else begin
                                bcnt <= bcnt + 32'd1;
                                for (int c = 0; c < CHANNELS; c++) begin
                                    sdata[c] <= sr[c][WIDTH-1];
                                    sr[c]    <= sr[c] << 1;
                                end
                            end
                        end
                    end else begin
                        hcnt <= hcnt + 32'd1;
                    end
                end
                LATCH: begin
                    if (cnt == 32'(LATCH_CYCLES-1)) begin
                        latch      <= 1'b1;
                        frame_done <= 1'b1;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                GAP: cnt <= cnt + 32'd1;
                default: begin
                end
            endcase
            if (load_new || load_hold) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    sdata[c] <= src_w[c][WIDTH-1];
                    sr[c]    <= src_w[c] << 1;
                end
                hcnt <= '0;
                bcnt <= '0;
                sclk <= 1'b0;
            end
            if (load_new) hold <= new_w;
        end
    end

endmodule

// File: tb/tb_led_chain_driver.sv
// Directed bench for led_chain_driver: three parameter sets driven through
// single-frame, two-channel, repeat, override and reset scenarios.
module tb_led_chain_driver;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // u_a: defaults
    logic [15:0] a_data;
    logic        a_valid, a_ready, a_rep, a_sclk, a_latch, a_busy, a_done;
    logic [0:0]  a_sdata;
    // u_b: two channels, DIV=2, no swap, LSB first, 4-cycle latch
    logic [31:0] b_data;
    logic        b_valid, b_ready, b_rep, b_sclk, b_latch, b_busy, b_done;
    logic [1:0]  b_sdata;
    // u_c: defaults with a 3-cycle gap
    logic [15:0] c_data;
    logic        c_valid, c_ready, c_rep, c_sclk, c_latch, c_busy, c_done;
    logic [0:0]  c_sdata;

    led_chain_driver u_a (
        .clk(clk), .rst(rst), .frame_data(a_data), .frame_valid(a_valid),
        .frame_ready(a_ready), .repeat_en(a_rep), .sclk(a_sclk),
        .sdata(a_sdata), .latch(a_latch), .busy(a_busy), .frame_done(a_done)
    );

    led_chain_driver #(
        .CHANNELS(2), .DIV(2), .BYTE_SWAP(0), .MSB_FIRST(0), .LATCH_CYCLES(4)
    ) u_b (
        .clk(clk), .rst(rst), .frame_data(b_data), .frame_valid(b_valid),
        .frame_ready(b_ready), .repeat_en(b_rep), .sclk(b_sclk),
        .sdata(b_sdata), .latch(b_latch), .busy(b_busy), .frame_done(b_done)
    );

    led_chain_driver #(.GAP_CYCLES(3)) u_c (
        .clk(clk), .rst(rst), .frame_data(c_data), .frame_valid(c_valid),
        .frame_ready(c_ready), .repeat_en(c_rep), .sclk(c_sclk),
        .sdata(c_sdata), .latch(c_latch), .busy(c_busy), .frame_done(c_done)
    );

    int         sel;
    logic       m_sclk, m_latch, m_done;
    logic [1:0] m_sd;

    always_comb begin
        m_sclk  = a_sclk;
        m_latch = a_latch;
        m_done  = a_done;
        m_sd    = {1'b0, a_sdata};
        if (sel == 1) begin
            m_sclk  = b_sclk;
            m_latch = b_latch;
            m_done  = b_done;
            m_sd    = b_sdata;
        end else if (sel == 2) begin
            m_sclk  = c_sclk;
            m_latch = c_latch;
            m_done  = c_done;
            m_sd    = c_sdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Observes the current cycle as cycle 1 of a frame and follows it to
    // frame_done (bounded). Bits are sampled on sclk rises, first bit ends
    // up in bit 15. viol counts sclk level lengths != div, sdata moving
    // other than at an sclk fall, sclk high or sdata moving during latch.
    task automatic capture(input int div, output logic [15:0] c0,
                           output logic [15:0] c1, output int l_at,
                           output int l_len, output int d_at,
                           output int viol);
        logic       ps;
        logic [1:0] psd;
        int         run;
        int         n;
        bit         fin;
        c0 = '0; c1 = '0; l_at = 0; l_len = 0; d_at = 0; viol = 0;
        ps = 1'b0; psd = m_sd; run = 0; n = 1; fin = 1'b0;
        while (!fin && n <= 200) begin
            if (m_done) begin
                d_at = n;
                if (!m_latch) viol++;
                fin = 1'b1;
            end else begin
                if (m_sclk && !ps) begin
                    c0 = {c0[14:0], m_sd[0]};
                    c1 = {c1[14:0], m_sd[1]};
                end
                if (m_sclk != ps) begin
                    if (run != div) viol++;
                    run = 1;
                end else begin
                    run++;
                end
                if (n > 1 && m_sd != psd && !(ps && !m_sclk && m_latch))
                    viol++;
                if (!m_latch) begin
                    if (l_at == 0) l_at = n;
                    l_len++;
                    if (m_sclk) viol++;
                end
                ps  = m_sclk;
                psd = m_sd;
                tick();
                n++;
            end
        end
    endtask

    logic [15:0] c0, c1;
    int          la, ll, da, v;

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({a_sclk, a_latch, a_sdata, a_busy, a_done} !== 5'b01000) begin
            n_fails++;
            $display("FAIL reset_outputs: got %b expected 01000",
                     {a_sclk, a_latch, a_sdata, a_busy, a_done});
        end
        n_checks++;
        if (a_ready !== 1'b0) begin
            n_fails++;
            $display("FAIL ready_in_reset: got %b expected 0", a_ready);
        end
        n_checks++;
        if ({b_latch, b_sdata, c_latch} !== 4'b1001) begin
            n_fails++;
            $display("FAIL reset_bc: got %b expected 1001",
                     {b_latch, b_sdata, c_latch});
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({a_ready, b_ready, c_ready} !== 3'b111) begin
            n_fails++;
            $display("FAIL ready_after_reset: got %b expected 111",
                     {a_ready, b_ready, c_ready});
        end
    endtask

    task automatic test_default_frame();
        sel = 0;
        a_data  = 16'hABCD;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        a_data  = 16'h0000;
        capture(1, c0, c1, la, ll, da, v);
        n_checks++;
        if (c0 !== 16'hCDAB) begin
            n_fails++;
            $display("FAIL def_bits: got %h expected cdab", c0);
        end
        n_checks++;
        if (la !== 33 || ll !== 1 || da !== 34) begin
            n_fails++;
            $display("FAIL def_latch: got at=%0d len=%0d done=%0d expected 33 1 34",
                     la, ll, da);
        end
        n_checks++;
        if (v !== 0) begin
            n_fails++;
            $display("FAIL def_timing: got %0d violations expected 0", v);
        end
        n_checks++;
        if (a_busy !== 1'b0 || a_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL def_idle: got busy=%b ready=%b expected 0 1",
                     a_busy, a_ready);
        end
    endtask

    task automatic test_two_channel();
        sel = 1;
        b_data  = 32'h8001_00FF;
        b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        b_data  = 32'hDEAD_BEEF;
        capture(2, c0, c1, la, ll, da, v);
        n_checks++;
        if (c0 !== 16'hFF00) begin
            n_fails++;
            $display("FAIL ch0_bits: got %h expected ff00", c0);
        end
        n_checks++;
        if (c1 !== 16'h8001) begin
            n_fails++;
            $display("FAIL ch1_bits: got %h expected 8001", c1);
        end
        n_checks++;
        if (la !== 65 || ll !== 4 || da !== 69) begin
            n_fails++;
            $display("FAIL two_latch: got at=%0d len=%0d done=%0d expected 65 4 69",
                     la, ll, da);
        end
        n_checks++;
        if (v !== 0) begin
            n_fails++;
            $display("FAIL two_timing: got %0d violations expected 0", v);
        end
    endtask

    task automatic test_repeat();
        sel = 2;
        c_rep   = 1'b1;
        c_data  = 16'h00F0;
        c_valid = 1'b1;
        tick();
        c_valid = 1'b0;
        c_data  = 16'h5555;
        for (int f = 0; f < 3; f++) begin
            capture(1, c0, c1, la, ll, da, v);
            n_checks++;
            if (c0 !== 16'hF000 || la !== 33 || da !== 34 || v !== 0) begin
                n_fails++;
                $display("FAIL repeat_frame%0d: got bits=%h at=%0d done=%0d viol=%0d expected f000 33 34 0",
                         f, c0, la, da, v);
            end
            tick();
            tick();
            n_checks++;
            if (c_busy !== 1'b1) begin
                n_fails++;
                $display("FAIL gap_busy%0d: got %b expected 1", f, c_busy);
            end
            tick();
            if (f == 1) c_rep = 1'b0;
        end
        n_checks++;
        if (c_busy !== 1'b0 || c_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL repeat_stop: got busy=%b ready=%b expected 0 1",
                     c_busy, c_ready);
        end
    endtask

    task automatic test_new_frame_wins();
        sel = 2;
        c_rep   = 1'b1;
        c_data  = 16'h00F0;
        c_valid = 1'b1;
        tick();
        c_data = 16'h1234;
        capture(1, c0, c1, la, ll, da, v);
        n_checks++;
        if (c0 !== 16'hF000 || da !== 34 || v !== 0) begin
            n_fails++;
            $display("FAIL busy_ignore: got bits=%h done=%0d viol=%0d expected f000 34 0",
                     c0, da, v);
        end
        repeat (3) tick();
        n_checks++;
        if (c_ready !== 1'b1 || c_busy !== 1'b0) begin
            n_fails++;
            $display("FAIL exit_idle: got ready=%b busy=%b expected 1 0",
                     c_ready, c_busy);
        end
        tick();
        c_valid = 1'b0;
        c_rep   = 1'b0;
        capture(1, c0, c1, la, ll, da, v);
        n_checks++;
        if (c0 !== 16'h3412 || la !== 33 || da !== 34 || v !== 0) begin
            n_fails++;
            $display("FAIL new_wins: got bits=%h at=%0d done=%0d viol=%0d expected 3412 33 34 0",
                     c0, la, da, v);
        end
        repeat (3) tick();
    endtask

    task automatic test_reset_mid_shift();
        int bad;
        sel = 0;
        a_data  = 16'hFFFF;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        repeat (14) tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if ({a_sclk, a_latch, a_sdata, a_busy, a_ready} !== 5'b01000) begin
            n_fails++;
            $display("FAIL mid_reset: got %b expected 01000",
                     {a_sclk, a_latch, a_sdata, a_busy, a_ready});
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (a_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL mid_ready: got %b expected 1", a_ready);
        end
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (!a_latch || a_done || a_sclk || a_busy) bad++;
            tick();
        end
        n_checks++;
        if (bad !== 0) begin
            n_fails++;
            $display("FAIL no_latch_pulse: got %0d bad cycles expected 0", bad);
        end
        a_data  = 16'hABCD;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        capture(1, c0, c1, la, ll, da, v);
        n_checks++;
        if (c0 !== 16'hCDAB || la !== 33 || da !== 34 || v !== 0) begin
            n_fails++;
            $display("FAIL post_reset: got bits=%h at=%0d done=%0d viol=%0d expected cdab 33 34 0",
                     c0, la, da, v);
        end
    endtask

    initial begin
        sel = 0;
        rst = 1'b1;
        a_data = '0; a_valid = 1'b0; a_rep = 1'b0;
        b_data = '0; b_valid = 1'b0; b_rep = 1'b0;
        c_data = '0; c_valid = 1'b0; c_rep = 1'b0;
        test_reset();
        test_default_frame();
        test_two_channel();
        test_repeat();
        test_new_frame_wins();
        test_reset_mid_shift();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
